// File: rtl/rom_writer.sv
// Byte-stream EEPROM programmer driving the shared multiplexed address bus and external low-address latch.
// Writes sequential addresses from 0, one timed latch/WE sequence per accepted byte.
module rom_writer #(
    parameter int PERIOD_NS       = 10,
    parameter int TOTAL_ADDRESSES = 32768,
    parameter int SETUP_NS        = 50,
    parameter int HOLD_NS         = 5,
    parameter int WE_PULSE_NS     = 100,
    parameter int WRITE_CYCLE_NS  = 10000000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        data_valid_in,
    input  logic [7:0]  data_in,
    output logic        data_ready_out,
    output logic [7:0]  rom_addr_out,
    output logic        rom_latch_out,
    output logic [7:0]  rom_data_out,
    output logic        rom_data_oe_out,
    output logic        rom_we_n_out,
    output logic [15:0] bytes_written_out,
    output logic        finished_out
);

    function automatic int ns2c(input int ns);
        int c;
        c = (ns + PERIOD_NS - 1) / PERIOD_NS;
        return (c < 1) ? 1 : c;
    endfunction

    localparam int SETUP_C = ns2c(SETUP_NS);
    localparam int HOLD_C  = ns2c(HOLD_NS);
    localparam int WE_C    = ns2c(WE_PULSE_NS);
    localparam int WC_C    = ns2c(WRITE_CYCLE_NS);
    localparam int MAX_AB  = (SETUP_C > HOLD_C) ? SETUP_C : HOLD_C;
    localparam int MAX_CD  = (WE_C > WC_C) ? WE_C : WC_C;
    localparam int MAX_C   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW      = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        IDLE, LOW_SETUP, LATCH_PULSE, HIGH_SETUP, WE_PULSE, DATA_HOLD, WRITE_WAIT, FINISHED
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [16:0]     addr, addr_next;
    logic [7:0]      byte_q, byte_next;
    logic [7:0]      addr_o_next, data_o_next;
    logic            latch_next, oe_next, we_n_next;
    logic            last;

    assign last = (cnt == '0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        addr_next  = addr;
        byte_next  = byte_q;
        unique case (state)
            IDLE: if (data_valid_in) begin
                byte_next  = data_in;
                state_next = LOW_SETUP;
                cnt_next   = CW'(SETUP_C - 1);
            end
            LOW_SETUP: if (last) begin
                state_next = LATCH_PULSE;
                cnt_next   = CW'(HOLD_C - 1);
            end else cnt_next = cnt - 1'b1;
            LATCH_PULSE: if (last) begin
                state_next = HIGH_SETUP;
                cnt_next   = CW'(SETUP_C - 1);
            end else cnt_next = cnt - 1'b1;
            HIGH_SETUP: if (last) begin
                state_next = WE_PULSE;
                cnt_next   = CW'(WE_C - 1);
            end else cnt_next = cnt - 1'b1;
            WE_PULSE: if (last) begin
                state_next = DATA_HOLD;
                cnt_next   = CW'(HOLD_C - 1);
            end else cnt_next = cnt - 1'b1;
            DATA_HOLD: if (last) begin
                state_next = WRITE_WAIT;
                cnt_next   = CW'(WC_C - 1);
            end else cnt_next = cnt - 1'b1;
            WRITE_WAIT: if (last) begin
                addr_next  = addr + 17'd1;
                state_next = (addr_next == 17'(TOTAL_ADDRESSES)) ? FINISHED : IDLE;
            end else cnt_next = cnt - 1'b1;
            default: state_next = state;
        endcase
    end

    // Bus outputs are decoded from the next state so the registered pins line up with the state register.
    always_comb begin
        addr_o_next = rom_addr_out;
        data_o_next = 8'h00;
        latch_next  = 1'b0;
        oe_next     = 1'b0;
        we_n_next   = 1'b1;
        unique case (state_next)
            LOW_SETUP:   addr_o_next = addr[7:0];
            LATCH_PULSE: begin
                addr_o_next = addr[7:0];
                latch_next  = 1'b1;
            end
            HIGH_SETUP, WE_PULSE, DATA_HOLD: begin
                addr_o_next = addr[15:8];
                data_o_next = byte_next;
                oe_next     = 1'b1;
                we_n_next   = (state_next != WE_PULSE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            cnt             <= '0;
            addr            <= '0;
            byte_q          <= '0;
            rom_addr_out    <= '0;
            rom_latch_out   <= 1'b0;
            rom_data_out    <= '0;
            rom_data_oe_out <= 1'b0;
            rom_we_n_out    <= 1'b1;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            addr            <= addr_next;
            byte_q          <= byte_next;
            rom_addr_out    <= addr_o_next;
            rom_latch_out   <= latch_next;
            rom_data_out    <= data_o_next;
            rom_data_oe_out <= oe_next;
            rom_we_n_out    <= we_n_next;
        end
    end

    assign data_ready_out    = (state == IDLE);
    assign finished_out      = (state == FINISHED);
    assign bytes_written_out = addr[15:0];

endmodule

// File: tb/tb_rom_writer.sv
// Directed bench for rom_writer: two instances (4-byte and 300-byte images) with a shared bus-protocol checker.
module tb_rom_writer;
    localparam int SETUP_C = 5;
    localparam int HOLD_C  = 1;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_a, valid_a, rdy_a, latch_a, oe_a, we_n_a, fin_a;
    logic [7:0] data_a, addr_a, dat_a;
    logic [15:0] bw_a;
    logic rst_b, valid_b, rdy_b, latch_b, oe_b, we_n_b, fin_b;
    logic [7:0] data_b, addr_b, dat_b;
    logic [15:0] bw_b;

    rom_writer #(.PERIOD_NS(10), .TOTAL_ADDRESSES(4), .WRITE_CYCLE_NS(200)) dut_a (
        .clk_in(clk_in), .rst_in(rst_a), .data_valid_in(valid_a), .data_in(data_a),
        .data_ready_out(rdy_a), .rom_addr_out(addr_a), .rom_latch_out(latch_a),
        .rom_data_out(dat_a), .rom_data_oe_out(oe_a), .rom_we_n_out(we_n_a),
        .bytes_written_out(bw_a), .finished_out(fin_a));

    rom_writer #(.PERIOD_NS(10), .TOTAL_ADDRESSES(300), .WRITE_CYCLE_NS(200)) dut_b (
        .clk_in(clk_in), .rst_in(rst_b), .data_valid_in(valid_b), .data_in(data_b),
        .data_ready_out(rdy_b), .rom_addr_out(addr_b), .rom_latch_out(latch_b),
        .rom_data_out(dat_b), .rom_data_oe_out(oe_b), .rom_we_n_out(we_n_b),
        .bytes_written_out(bw_b), .finished_out(fin_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Protocol checker over both instances, sampled on the falling edge.
    logic       rst_seen [2];
    logic       prev_we  [2];
    logic       prev_oe  [2];
    logic [7:0] prev_dat [2];
    int         stable   [2];
    int         hold_left[2];
    logic [7:0] we_q_a[$];
    logic       l_w[2], o_w[2], w_w[2];
    logic [7:0] d_w[2];

    assign l_w[0] = latch_a;  assign l_w[1] = latch_b;
    assign o_w[0] = oe_a;     assign o_w[1] = oe_b;
    assign w_w[0] = we_n_a;   assign w_w[1] = we_n_b;
    assign d_w[0] = dat_a;    assign d_w[1] = dat_b;

    always @(posedge clk_in) begin
        rst_seen[0] = rst_a;
        rst_seen[1] = rst_b;
    end

    always @(negedge clk_in) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_seen[d] !== 1'b0) begin
                stable[d] = 0; hold_left[d] = 0;
                prev_we[d] = 1'b1; prev_oe[d] = 1'b0; prev_dat[d] = 8'h00;
            end else begin
                if (!w_w[d]) begin
                    chk("latch_with_we", {31'd0, l_w[d]}, 32'd0);
                    chk("oe_during_we", {31'd0, o_w[d]}, 32'd1);
                end
                if (o_w[d] && prev_oe[d] && d_w[d] === prev_dat[d]) stable[d]++;
                else stable[d] = o_w[d] ? 1 : 0;
                if (!w_w[d] && prev_we[d]) begin
                    chk("data_setup", {31'd0, stable[d] >= SETUP_C + 1}, 32'd1);
                    if (d == 0) we_q_a.push_back(d_w[d]);
                end
                if (!w_w[d] && !prev_we[d]) chk("data_stable_we", {24'd0, d_w[d]}, {24'd0, prev_dat[d]});
                if (w_w[d] && !prev_we[d]) begin
                    chk("data_hold", {24'd0, d_w[d]}, {24'd0, prev_dat[d]});
                    chk("oe_hold", {31'd0, o_w[d]}, 32'd1);
                    hold_left[d] = HOLD_C - 1;
                end else if (hold_left[d] > 0) begin
                    chk("data_hold", {24'd0, d_w[d]}, {24'd0, prev_dat[d]});
                    chk("oe_hold", {31'd0, o_w[d]}, 32'd1);
                    hold_left[d]--;
                end
                prev_we[d] = w_w[d]; prev_oe[d] = o_w[d]; prev_dat[d] = d_w[d];
            end
        end
    end

    // Per-cycle trace after an accept edge: index k is the sample following the k-th edge after accept.
    logic [7:0]  tr_addr[64], tr_dat[64];
    logic        tr_latch[64], tr_oe[64], tr_we[64], tr_rdy[64];
    logic [15:0] tr_bw[64];

    task automatic capture(input int sel, input int n, input bit tog);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            if (sel == 0) begin
                tr_addr[k] = addr_a; tr_dat[k] = dat_a; tr_latch[k] = latch_a;
                tr_oe[k] = oe_a; tr_we[k] = we_n_a; tr_rdy[k] = rdy_a; tr_bw[k] = bw_a;
                if (k == 0) valid_a = 1'b0;
                if (tog) begin
                    data_a  = 8'($urandom);
                    valid_a = (k < 40) ? 1'($urandom) : 1'b0;
                end
            end else begin
                tr_addr[k] = addr_b; tr_dat[k] = dat_b; tr_latch[k] = latch_b;
                tr_oe[k] = oe_b; tr_we[k] = we_n_b; tr_rdy[k] = rdy_b; tr_bw[k] = bw_b;
                if (k == 0) valid_b = 1'b0;
            end
        end
    endtask

    initial begin
        int n_latch, n_we, n_oe, first_we, first_rdy, first_latch, cyc;
        logic [7:0] stream[4];
        stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;

        rst_a = 1'b1; valid_a = 1'b0; data_a = 8'h00;
        rst_b = 1'b1; valid_b = 1'b0; data_b = 8'h00;
        repeat (3) @(negedge clk_in);
        chk("rst_addr",  {24'd0, addr_a}, 32'h0);
        chk("rst_latch", {31'd0, latch_a}, 32'd0);
        chk("rst_data",  {24'd0, dat_a}, 32'h0);
        chk("rst_oe",    {31'd0, oe_a}, 32'd0);
        chk("rst_we_n",  {31'd0, we_n_a}, 32'd1);
        chk("rst_bw",    {16'd0, bw_a}, 32'd0);
        chk("rst_fin",   {31'd0, fin_a}, 32'd0);
        chk("rst_ready", {31'd0, rdy_a}, 32'd1);

        // single write of 0xA5 at reset release
        rst_a = 1'b0; valid_a = 1'b1; data_a = 8'hA5;
        @(posedge clk_in);
        capture(0, 43, 1'b0);
        n_latch = 0; n_we = 0; n_oe = 0; first_we = -1; first_rdy = -1; first_latch = -1;
        for (int k = 0; k < 43; k++) begin
            if (tr_latch[k]) begin n_latch++; if (first_latch < 0) first_latch = k; end
            if (!tr_we[k]) begin n_we++; if (first_we < 0) first_we = k; end
            if (tr_oe[k]) n_oe++;
            if (tr_rdy[k] && first_rdy < 0) first_rdy = k;
        end
        chk("t1_latch_cycles", n_latch, 1);
        chk("t1_latch_index",  first_latch, 5);
        chk("t1_we_cycles",    n_we, 10);
        chk("t1_we_index",     first_we, 11);
        chk("t1_oe_cycles",    n_oe, 16);
        chk("t1_low_addr",     {24'd0, tr_addr[0]}, 32'h00);
        chk("t1_low_oe",       {31'd0, tr_oe[0]}, 32'd0);
        chk("t1_setup_data",   {24'd0, tr_dat[6]}, 32'hA5);
        chk("t1_we_data",      {24'd0, tr_dat[11]}, 32'hA5);
        chk("t1_we_addr",      {24'd0, tr_addr[11]}, 32'h00);
        chk("t1_ready_latency", first_rdy, 42);
        chk("t1_bytes_written", {16'd0, tr_bw[42]}, 32'd1);

        // data_in and valid toggled while the write is in flight
        valid_a = 1'b1; data_a = 8'h3C;
        @(posedge clk_in);
        capture(0, 43, 1'b1);
        for (int k = 11; k < 21; k++) chk("t4_we_data", {24'd0, tr_dat[k]}, 32'h3C);
        chk("t4_bytes_written", {16'd0, tr_bw[42]}, 32'd2);
        chk("t4_ready_back", {31'd0, tr_rdy[42]}, 32'd1);
        data_a = 8'h00;

        // reset during the WE pulse
        valid_a = 1'b1; data_a = 8'h5A;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_a = 1'b0;
        repeat (14) @(negedge clk_in);
        chk("t5_in_we", {31'd0, we_n_a}, 32'd0);
        rst_a = 1'b1;
        @(negedge clk_in);
        rst_a = 1'b0;
        chk("t5_we_n",  {31'd0, we_n_a}, 32'd1);
        chk("t5_oe",    {31'd0, oe_a}, 32'd0);
        chk("t5_latch", {31'd0, latch_a}, 32'd0);
        chk("t5_bw",    {16'd0, bw_a}, 32'd0);
        chk("t5_ready", {31'd0, rdy_a}, 32'd1);
        chk("t5_data",  {24'd0, dat_a}, 32'h0);
        valid_a = 1'b1; data_a = 8'h77;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_a = 1'b0;
        repeat (42) @(negedge clk_in);
        chk("t5_restart_bw", {16'd0, bw_a}, 32'd1);

        // back-to-back stream to completion
        rst_a = 1'b1;
        @(negedge clk_in);
        rst_a = 1'b0;
        we_q_a.delete();
        valid_a = 1'b1; data_a = stream[0];
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            while (!rdy_a && cyc < 100) begin @(negedge clk_in); cyc++; end
            chk("t3_ready_timeout", {31'd0, cyc < 100}, 32'd1);
            @(posedge clk_in);
            @(negedge clk_in);
            data_a = (i < 3) ? stream[i + 1] : 8'hEE;
        end
        repeat (41) @(negedge clk_in);
        chk("t3_fin_early", {31'd0, fin_a}, 32'd0);
        @(negedge clk_in);
        chk("t3_fin", {31'd0, fin_a}, 32'd1);
        chk("t3_bw",  {16'd0, bw_a}, 32'd4);
        n_we = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_in);
            if (rdy_a || !we_n_a || !fin_a) n_we++;
        end
        chk("t3_stays_finished", n_we, 0);
        chk("t3_we_count", we_q_a.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t3_we_order", {24'd0, (i < we_q_a.size()) ? we_q_a[i] : 8'hXX}, {24'd0, stream[i]});
        valid_a = 1'b0;

        // preload 258 bytes then check the 0x0102 write
        rst_b = 1'b0; valid_b = 1'b1; data_b = 8'h00;
        cyc = 0;
        while (bw_b != 16'd258 && cyc < 12000) begin @(negedge clk_in); cyc++; end
        chk("t2_preload_timeout", {31'd0, cyc < 12000}, 32'd1);
        chk("t2_ready_at_258", {31'd0, rdy_b}, 32'd1);
        data_b = 8'h99;
        @(posedge clk_in);
        capture(1, 43, 1'b0);
        chk("t2_low_addr",   {24'd0, tr_addr[0]}, 32'h02);
        chk("t2_latch",      {31'd0, tr_latch[5]}, 32'd1);
        chk("t2_latch_addr", {24'd0, tr_addr[5]}, 32'h02);
        chk("t2_we_low",     {31'd0, tr_we[11]}, 32'd0);
        chk("t2_high_addr",  {24'd0, tr_addr[11]}, 32'h01);
        chk("t2_we_data",    {24'd0, tr_dat[11]}, 32'h99);
        chk("t2_bw",         {16'd0, tr_bw[42]}, 32'd259);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
